gbc_mem_arbiter: RTL and testbench



---
 rtl/gbc_mem_pkg.sv | 41 ++++
 rtl/gbc_rr_arbiter.sv | 43 ++++
 rtl/gbc_mem_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_gbc_mem_arbiter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/gbc_mem_pkg.sv
// Shared types and helpers for the gbc memory arbiter and its arbitration core.
package gbc_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  localparam logic [7:0] OPEN_BUS_DFLT = 8'hFF;

  // Decode works on padded vectors so one function serves any region count
  // up to DEC_MAX_R and any address width up to DEC_AW.
  localparam int DEC_MAX_R = 16;
  localparam int DEC_AW    = 32;

  typedef struct packed {
    logic                 hit;
    logic [DEC_MAX_R-1:0] sel;
  } dec_t;

  // Lowest matching region wins; scanning downward lets lower indices overwrite.
  function automatic dec_t region_decode(
    input logic [DEC_AW-1:0]           addr,
    input logic [DEC_MAX_R*DEC_AW-1:0] base,
    input logic [DEC_MAX_R*DEC_AW-1:0] high,
    input int                          nreg
  );
    dec_t d;
    d = '0;
    for (int r = DEC_MAX_R - 1; r >= 0; r--) begin
      if (r < nreg && addr >= base[r*DEC_AW +: DEC_AW] && addr <= high[r*DEC_AW +: DEC_AW]) begin
        d.sel    = '0;
        d.sel[r] = 1'b1;
        d.hit    = 1'b1;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/gbc_rr_arbiter.sv
// Round-robin / fixed-priority arbiter: one-hot grant plus rotating pointer.
module gbc_rr_arbiter #(
  parameter  int P_N  = 4,
  localparam int PW   = (P_N > 1) ? $clog2(P_N) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [P_N-1:0] req,
  input  logic           en,
  input  logic           rr_mode,
  output logic [P_N-1:0] gnt,
  output logic [PW-1:0]  gidx
);

  logic [PW-1:0] ptr;
  logic          found;
  int            c;

  // Search from the pointer (round-robin) or from index 0 (fixed priority).
  always_comb begin
    gnt   = '0;
    gidx  = '0;
    found = 1'b0;
    c     = 0;
    for (int i = 0; i < P_N; i++) begin
      c = rr_mode ? ((int'(ptr) + i) % P_N) : i;
      if (en && !found && req[c]) begin
        found  = 1'b1;
        gnt[c] = 1'b1;
        gidx   = PW'(c);
      end
    end
  end

  // Pointer moves past the winner so it gets the lowest priority next time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ptr <= '0;
    else if (found)
      ptr <= (gidx == PW'(P_N - 1)) ? '0 : gidx + 1'b1;
  end

endmodule

// File: rtl/gbc_mem_arbiter.sv
// Clocked arbiter routing N memory masters onto M decoded slave regions.
module gbc_mem_arbiter
  import gbc_mem_pkg::*;
#(
  parameter int P_NUM_MASTERS = 4,
  parameter int P_NUM_REGIONS = 4,
  parameter int P_ADDR_W      = 16,
  parameter int P_DATA_W      = 8,
  parameter logic [P_NUM_REGIONS*P_ADDR_W-1:0] P_REGION_BASE = {P_NUM_REGIONS{16'h0000}},
  parameter logic [P_NUM_REGIONS*P_ADDR_W-1:0] P_REGION_HIGH = {P_NUM_REGIONS{16'hFFFF}},
  parameter bit   P_RR_EN     = 1'b1,
  parameter int   P_TIMEOUT   = 16,
  parameter logic [P_DATA_W-1:0] P_OPEN_BUS = P_DATA_W'(OPEN_BUS_DFLT)
) (
  input  logic                              I_CLK,
  input  logic                              I_RESET,
  input  logic [P_NUM_MASTERS-1:0]          I_REQ,
  input  logic [P_NUM_MASTERS-1:0]          I_WE,
  input  logic [P_NUM_MASTERS*P_ADDR_W-1:0] I_ADDR,
  input  logic [P_NUM_MASTERS*P_DATA_W-1:0] I_WDATA,
  output logic [P_NUM_MASTERS-1:0]          O_ACK,
  output logic [P_NUM_MASTERS-1:0]          O_ERR,
  output logic [P_DATA_W-1:0]               O_RDATA,
  output logic [P_NUM_REGIONS-1:0]          O_SLV_SEL,
  output logic [P_ADDR_W-1:0]               O_SLV_ADDR,
  output logic [P_DATA_W-1:0]               O_SLV_WDATA,
  output logic                              O_SLV_WE,
  output logic                              O_SLV_RE,
  input  logic [P_NUM_REGIONS-1:0]          I_SLV_ACK,
  input  logic [P_NUM_REGIONS*P_DATA_W-1:0] I_SLV_RDATA,
  output logic                              O_BUSY
);

  localparam int NM = P_NUM_MASTERS;
  localparam int NR = P_NUM_REGIONS;
  localparam int AW = P_ADDR_W;
  localparam int DW = P_DATA_W;
  localparam int IW = (NM > 1) ? $clog2(NM) : 1;
  localparam int TW = (P_TIMEOUT > 0) ? $clog2(P_TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'((P_TIMEOUT > 0) ? P_TIMEOUT - 1 : 0);

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [NR-1:0] sel_q, sel_d;
  logic          swe_q, swe_d, sre_q, sre_d;
  logic [NM-1:0] ack_q, ack_d, err_q, err_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [TW-1:0] cnt_q, cnt_d;

  logic [NM-1:0] gnt;
  logic [IW-1:0] gidx;
  logic [AW-1:0] gaddr;
  logic [DW-1:0] sel_rdata;
  logic [DEC_MAX_R*DEC_AW-1:0] base_pad, high_pad;
  dec_t          dec;

  gbc_rr_arbiter #(.P_N(NM)) u_arb (
    .clk     (I_CLK),
    .rst     (I_RESET),
    .req     (I_REQ),
    .en      (state_q == ST_IDLE),
    .rr_mode (P_RR_EN),
    .gnt     (gnt),
    .gidx    (gidx)
  );

  // Widen region bounds to the decoder's fixed width; unused regions stay zero.
  always_comb begin
    base_pad = '0;
    high_pad = '0;
    for (int r = 0; r < NR; r++) begin
      base_pad[r*DEC_AW +: DEC_AW] = DEC_AW'(P_REGION_BASE[r*AW +: AW]);
      high_pad[r*DEC_AW +: DEC_AW] = DEC_AW'(P_REGION_HIGH[r*AW +: AW]);
    end
  end

  // Decode the granted master's address and pick the selected slave's read data.
  always_comb begin
    gaddr     = I_ADDR[gidx*AW +: AW];
    dec       = region_decode(DEC_AW'(gaddr), base_pad, high_pad, NR);
    sel_rdata = '0;
    for (int r = 0; r < NR; r++)
      if (sel_q[r]) sel_rdata = sel_rdata | I_SLV_RDATA[r*DW +: DW];
  end

  generate
    if (NR < DEC_MAX_R) begin : g_dec_pad
      logic dec_unused;
      assign dec_unused = ^dec.sel[DEC_MAX_R-1:NR];
    end
  endgenerate

  // Next-state and registered-output logic; response outputs default to idle.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    sel_d   = sel_q;
    swe_d   = swe_q;
    sre_d   = sre_q;
    cnt_d   = cnt_q;
    ack_d   = '0;
    err_d   = '0;
    rdata_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (|gnt) begin
          idx_d   = gidx;
          we_d    = I_WE[gidx];
          addr_d  = gaddr;
          wdata_d = I_WDATA[gidx*DW +: DW];
          if (dec.hit) begin
            state_d = ST_ACCESS;
            sel_d   = dec.sel[NR-1:0];
            swe_d   = I_WE[gidx];
            sre_d   = ~I_WE[gidx];
            cnt_d   = '0;
          end else begin
            state_d     = ST_RESP;
            ack_d[gidx] = 1'b1;
            err_d[gidx] = 1'b1;
            rdata_d     = P_OPEN_BUS;
          end
        end
      end
      ST_ACCESS: begin
        if (|(I_SLV_ACK & sel_q)) begin
          state_d      = ST_RESP;
          ack_d[idx_q] = 1'b1;
          rdata_d      = we_q ? '0 : sel_rdata;
          sel_d        = '0;
          swe_d        = 1'b0;
          sre_d        = 1'b0;
        end else if (P_TIMEOUT != 0 && cnt_q == TO_LAST) begin
          state_d      = ST_RESP;
          ack_d[idx_q] = 1'b1;
          err_d[idx_q] = 1'b1;
          rdata_d      = P_OPEN_BUS;
          sel_d        = '0;
          swe_d        = 1'b0;
          sre_d        = 1'b0;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset aborts any transaction silently.
  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      sel_q   <= '0;
      swe_q   <= 1'b0;
      sre_q   <= 1'b0;
      cnt_q   <= '0;
      ack_q   <= '0;
      err_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      sel_q   <= sel_d;
      swe_q   <= swe_d;
      sre_q   <= sre_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign O_ACK       = ack_q;
  assign O_ERR       = err_q;
  assign O_RDATA     = rdata_q;
  assign O_SLV_SEL   = sel_q;
  assign O_SLV_ADDR  = addr_q;
  assign O_SLV_WDATA = wdata_q;
  assign O_SLV_WE    = swe_q;
  assign O_SLV_RE    = sre_q;
  assign O_BUSY      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_gbc_mem_arbiter.sv
// Directed bench: round-robin DUT with a wait-state slave model, plus a fixed-priority DUT.
module tb_gbc_mem_arbiter;

  localparam int NM = 4, NR = 4, AW = 16, DW = 8;
  // r0 IO FF00-FFFF, r1 cart 0000-7FFF, r2 WRAM C000-DFFF, r3 VRAM 8000-9FFF
  localparam logic [NR*AW-1:0] BASE = {16'h8000, 16'hC000, 16'h0000, 16'hFF00};
  localparam logic [NR*AW-1:0] HIGH = {16'h9FFF, 16'hDFFF, 16'h7FFF, 16'hFFFF};

  logic clk, rst;
  logic [NM-1:0] req, req_f, we;
  logic [NM*AW-1:0] addr;
  logic [NM*DW-1:0] wdata;
  logic [NM-1:0] ack, err, ack_f, err_f;
  logic [DW-1:0] rdata, rdata_f, slv_wdata, slv_wdata_f;
  logic [NR-1:0] slv_sel, slv_sel_f, slv_ack, slv_ack_f;
  logic [AW-1:0] slv_addr, slv_addr_f;
  logic slv_we, slv_re, busy, slv_we_f, slv_re_f, busy_f;
  logic [NR*DW-1:0] slv_rdata;

  logic       ack_en;
  logic [7:0] wait_n, wcnt;
  logic [7:0] rd_val;

  int n_chk, n_fail;

  assign slv_ack   = (ack_en && wcnt == wait_n) ? slv_sel : '0;
  assign slv_ack_f = slv_sel_f;
  assign slv_rdata = {NR{rd_val}};

  always @(posedge clk)
    if (rst) wcnt <= '0;
    else     wcnt <= (|slv_sel && !(|slv_ack)) ? wcnt + 8'd1 : 8'd0;

  always #5 clk = ~clk;

  gbc_mem_arbiter #(.P_REGION_BASE(BASE), .P_REGION_HIGH(HIGH), .P_RR_EN(1'b1), .P_TIMEOUT(16)) u_dut (
    .I_CLK(clk), .I_RESET(rst), .I_REQ(req), .I_WE(we), .I_ADDR(addr), .I_WDATA(wdata),
    .O_ACK(ack), .O_ERR(err), .O_RDATA(rdata), .O_SLV_SEL(slv_sel), .O_SLV_ADDR(slv_addr),
    .O_SLV_WDATA(slv_wdata), .O_SLV_WE(slv_we), .O_SLV_RE(slv_re), .I_SLV_ACK(slv_ack),
    .I_SLV_RDATA(slv_rdata), .O_BUSY(busy));

  gbc_mem_arbiter #(.P_REGION_BASE(BASE), .P_REGION_HIGH(HIGH), .P_RR_EN(1'b0), .P_TIMEOUT(16)) u_fix (
    .I_CLK(clk), .I_RESET(rst), .I_REQ(req_f), .I_WE(we), .I_ADDR(addr), .I_WDATA(wdata),
    .O_ACK(ack_f), .O_ERR(err_f), .O_RDATA(rdata_f), .O_SLV_SEL(slv_sel_f), .O_SLV_ADDR(slv_addr_f),
    .O_SLV_WDATA(slv_wdata_f), .O_SLV_WE(slv_we_f), .O_SLV_RE(slv_re_f), .I_SLV_ACK(slv_ack_f),
    .I_SLV_RDATA(slv_rdata), .O_BUSY(busy_f));

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic set_master(input int m, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    we[m] = w;
    addr[m*AW +: AW] = a;
    wdata[m*DW +: DW] = d;
  endtask

  task automatic test_reset;
    tick; tick;
    n_chk++; if (ack !== '0 || err !== '0) begin n_fail++; $display("FAIL reset_ack: ack=%b err=%b want 0", ack, err); end
    n_chk++; if (rdata !== '0) begin n_fail++; $display("FAIL reset_rdata: got %h want 00", rdata); end
    n_chk++; if (slv_sel !== '0 || slv_we !== 0 || slv_re !== 0 || slv_addr !== '0 || slv_wdata !== '0) begin
      n_fail++; $display("FAIL reset_slave: sel=%b we=%b re=%b addr=%h wd=%h want 0", slv_sel, slv_we, slv_re, slv_addr, slv_wdata); end
    n_chk++; if (busy !== 0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst = 0;
    tick;
  endtask

  task automatic test_single_read;
    rd_val = 8'h5A; wait_n = 0; ack_en = 1;
    set_master(0, 1'b0, 16'hC000, 8'h00);
    req = 4'b0001;
    tick;
    n_chk++; if (slv_sel !== 4'b0100 || slv_re !== 1 || slv_we !== 0 || slv_addr !== 16'hC000) begin
      n_fail++; $display("FAIL rd_strobe: sel=%b re=%b we=%b addr=%h want 0100/1/0/c000", slv_sel, slv_re, slv_we, slv_addr); end
    n_chk++; if (ack !== '0 || busy !== 1) begin n_fail++; $display("FAIL rd_early: ack=%b busy=%b want 0000/1", ack, busy); end
    tick;
    n_chk++; if (ack !== 4'b0001 || err !== '0) begin n_fail++; $display("FAIL rd_ack: ack=%b err=%b want 0001/0000", ack, err); end
    n_chk++; if (rdata !== 8'h5A || slv_sel !== '0) begin n_fail++; $display("FAIL rd_data: rdata=%h sel=%b want 5a/0000", rdata, slv_sel); end
    req = '0;
    tick;
    n_chk++; if (ack !== '0 || busy !== 0) begin n_fail++; $display("FAIL rd_done: ack=%b busy=%b want 0000/0", ack, busy); end
  endtask

  task automatic test_round_robin;
    logic [NM-1:0] got, exp;
    rst = 1; tick; rst = 0; tick;
    rd_val = 8'h11;
    for (int m = 0; m < NM; m++) set_master(m, 1'b0, 16'h0100 + 16'(m), 8'h00);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp = 4'(1 << (k % 4));
      got = '0;
      for (int c = 0; c < 12; c++) begin
        tick;
        if (ack !== '0) begin got = ack; break; end
      end
      n_chk++; if (got !== exp) begin n_fail++; $display("FAIL rr_grant%0d: got %b want %b", k, got, exp); end
    end
    req = '0;
    tick;
  endtask

  task automatic test_fixed_priority;
    logic [NM-1:0] got;
    req_f = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      got = '0;
      for (int c = 0; c < 12; c++) begin
        tick;
        if (ack_f !== '0) begin got = ack_f; break; end
      end
      n_chk++; if (got !== 4'b0001) begin n_fail++; $display("FAIL fixed_grant%0d: got %b want 0001", k, got); end
    end
    req_f = '0;
    tick; tick;
  endtask

  task automatic test_unmapped_write;
    set_master(1, 1'b1, 16'hFEA0, 8'h33);
    req = 4'b0010;
    tick;
    n_chk++; if (ack !== 4'b0010 || err !== 4'b0010) begin n_fail++; $display("FAIL unmap_ack: ack=%b err=%b want 0010/0010", ack, err); end
    n_chk++; if (rdata !== 8'hFF) begin n_fail++; $display("FAIL unmap_rdata: got %h want ff", rdata); end
    n_chk++; if (slv_sel !== '0 || slv_we !== 0 || slv_re !== 0) begin
      n_fail++; $display("FAIL unmap_strobe: sel=%b we=%b re=%b want 0", slv_sel, slv_we, slv_re); end
    req = '0; we = '0;
    tick;
    n_chk++; if (ack !== '0 || busy !== 0) begin n_fail++; $display("FAIL unmap_done: ack=%b busy=%b want 0000/0", ack, busy); end
  endtask

  task automatic test_timeout;
    ack_en = 0;
    set_master(2, 1'b0, 16'h8000, 8'h00);
    req = 4'b0100;
    tick;
    for (int i = 0; i < 16; i++) begin
      n_chk++; if (slv_sel !== 4'b1000 || slv_re !== 1 || ack !== '0) begin
        n_fail++; $display("FAIL to_hold%0d: sel=%b re=%b ack=%b want 1000/1/0000", i, slv_sel, slv_re, ack); end
      tick;
    end
    n_chk++; if (ack !== 4'b0100 || err !== 4'b0100) begin n_fail++; $display("FAIL to_err: ack=%b err=%b want 0100/0100", ack, err); end
    n_chk++; if (rdata !== 8'hFF || slv_sel !== '0 || slv_re !== 0) begin
      n_fail++; $display("FAIL to_resp: rdata=%h sel=%b re=%b want ff/0000/0", rdata, slv_sel, slv_re); end
    req = '0;
    tick;
    n_chk++; if (busy !== 0 || ack !== '0) begin n_fail++; $display("FAIL to_idle: busy=%b ack=%b want 0/0000", busy, ack); end
    ack_en = 1;
  endtask

  task automatic test_wait_drop;
    int pulses;
    wait_n = 3;
    set_master(3, 1'b1, 16'hC123, 8'hA5);
    req = 4'b1000;
    tick;
    req = '0;
    for (int i = 0; i < 4; i++) begin
      n_chk++; if (slv_we !== 1 || slv_re !== 0 || slv_sel !== 4'b0100 || slv_wdata !== 8'hA5 || ack !== '0) begin
        n_fail++; $display("FAIL wait_we%0d: we=%b re=%b sel=%b wd=%h ack=%b want 1/0/0100/a5/0000", i, slv_we, slv_re, slv_sel, slv_wdata, ack); end
      tick;
    end
    n_chk++; if (ack !== 4'b1000 || err !== '0 || rdata !== 8'h00) begin
      n_fail++; $display("FAIL wait_ack: ack=%b err=%b rdata=%h want 1000/0000/00", ack, err, rdata); end
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      tick;
      if (ack !== '0) pulses++;
    end
    n_chk++; if (pulses !== 0 || slv_we !== 0) begin n_fail++; $display("FAIL wait_once: extra acks=%0d we=%b want 0/0", pulses, slv_we); end
    wait_n = 0; we = '0;
  endtask

  task automatic test_reset_mid;
    ack_en = 0;
    set_master(0, 1'b0, 16'hC000, 8'h00);
    req = 4'b0001;
    tick;
    n_chk++; if (busy !== 1 || slv_sel !== 4'b0100) begin n_fail++; $display("FAIL mid_access: busy=%b sel=%b want 1/0100", busy, slv_sel); end
    #1 rst = 1;
    #1;
    n_chk++; if (busy !== 0 || slv_sel !== '0 || slv_re !== 0 || slv_we !== 0 || ack !== '0 || slv_addr !== '0) begin
      n_fail++; $display("FAIL mid_abort: busy=%b sel=%b re=%b we=%b ack=%b addr=%h want 0", busy, slv_sel, slv_re, slv_we, ack, slv_addr); end
    req = '0;
    tick; tick;
    rst = 0; ack_en = 1;
    tick;
    n_chk++; if (ack !== '0 || busy !== 0) begin n_fail++; $display("FAIL mid_noack: ack=%b busy=%b want 0000/0", ack, busy); end
    rd_val = 8'h77;
    set_master(3, 1'b0, 16'h0200, 8'h00);
    req = 4'b1001;
    tick;
    n_chk++; if (slv_sel !== 4'b0100 || slv_addr !== 16'hC000) begin
      n_fail++; $display("FAIL mid_ptr0: sel=%b addr=%h want 0100/c000", slv_sel, slv_addr); end
    tick;
    n_chk++; if (ack !== 4'b0001 || rdata !== 8'h77) begin n_fail++; $display("FAIL mid_after: ack=%b rdata=%h want 0001/77", ack, rdata); end
    req = '0;
    tick;
  endtask

  initial begin
    clk = 0; rst = 1;
    req = '0; req_f = '0; we = '0; addr = '0; wdata = '0;
    ack_en = 1; wait_n = 0; rd_val = 8'h00;
    n_chk = 0; n_fail = 0;
    test_reset;
    test_single_read;
    test_round_robin;
    test_fixed_priority;
    test_unmapped_write;
    test_timeout;
    test_wait_drop;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
